// File: rtl/sgbm_aggr_path.sv
// sgbm_aggr_path: single-direction SGBM path aggregation over one scanline with a column-ordered line buffer; define SGBM_AGGR_WTA_EN to add the o_best_disp winner-take-all output
module sgbm_aggr_path #(
  parameter int DISPD = 64,
  parameter int COST_BITS = 12,
  parameter int WIDTH_BITS = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line_start,
  input  logic i_dir,
  input  logic [WIDTH_BITS-1:0] i_width,
  input  logic [$clog2(DISPD):0] i_min_disp,
  input  logic [$clog2(DISPD):0] i_max_disp,
  input  logic [COST_BITS-1:0] i_P1,
  input  logic [COST_BITS-1:0] i_P2,
  input  logic [DISPD*COST_BITS-1:0] i_cost,
  input  logic i_valid,
  output logic o_ready,
  output logic [DISPD*COST_BITS-1:0] o_cost,
  output logic o_valid,
  input  logic i_out_ready,
  input  logic [WIDTH_BITS-1:0] i_rd_addr,
  output logic [DISPD*COST_BITS-1:0] o_rd_data,
  output logic o_line_done,
  output logic o_busy
`ifdef SGBM_AGGR_WTA_EN
  ,
  output logic [$clog2(DISPD)-1:0] o_best_disp
`endif
);
  localparam int DB = $clog2(DISPD) + 1;
  localparam int E = COST_BITS + 2;
  localparam logic [COST_BITS-1:0] MAXC = '1;
  localparam logic [E-1:0] MAXE = {2'b00, MAXC};
`ifdef SGBM_AGGR_WTA_EN
  localparam int LW = $clog2(DISPD);
  logic [LW-1:0] best;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state;
  logic dir_q;
  logic [WIDTH_BITS-1:0] width_q, n, wr_addr;
  logic [DB-1:0] min_q, max_q;
  logic [COST_BITS-1:0] p1_q, p2_q, min_lp, lr_min;
  logic [COST_BITS-1:0] lp [DISPD];
  logic [COST_BITS-1:0] lr [DISPD];
  logic [E-1:0] lpx [DISPD+2];
  logic [E-1:0] m, s;
  logic [DB:0] diff, r;
  logic [DISPD*COST_BITS-1:0] lr_flat;
  logic acc;
  logic [DISPD*COST_BITS-1:0] mem [2**WIDTH_BITS];
  assign diff = {1'b0, max_q} - {1'b0, min_q};
  assign r = (!diff[DB] && diff != '0) ? diff : (DB+1)'(1);
  assign o_busy = state != IDLE;
  assign o_ready = state == RUN && n != width_q && (!o_valid || i_out_ready);
  assign acc = i_valid && o_ready && !i_line_start;
  assign wr_addr = dir_q ? width_q - n - 1'b1 : n;
  // Lr for every lane; out-of-range neighbours and inactive lanes read as MAX_COST
  always_comb begin
    lpx[0] = MAXE;
    lpx[DISPD+1] = MAXE;
    for (int d = 0; d < DISPD; d++) lpx[d+1] = (d < int'(r)) ? {2'b00, lp[d]} : MAXE;
    lr_min = MAXC;
    lr_flat = '0;
    m = '0;
    s = '0;
`ifdef SGBM_AGGR_WTA_EN
    best = '0;
`endif
    for (int d = 0; d < DISPD; d++) begin
      m = lpx[d+1];
      m = (lpx[d] + {2'b00, p1_q} < m) ? lpx[d] + {2'b00, p1_q} : m;
      m = (lpx[d+2] + {2'b00, p1_q} < m) ? lpx[d+2] + {2'b00, p1_q} : m;
      m = ({2'b00, min_lp} + {2'b00, p2_q} < m) ? {2'b00, min_lp} + {2'b00, p2_q} : m;
      s = {2'b00, i_cost[d*COST_BITS +: COST_BITS]} + m - {2'b00, min_lp};
      lr[d] = (d >= int'(r) || s > MAXE) ? MAXC : s[COST_BITS-1:0];
      if (d < int'(r) && lr[d] < lr_min) begin
        lr_min = lr[d];
`ifdef SGBM_AGGR_WTA_EN
        best = LW'(d);
`endif
      end
      lr_flat[d*COST_BITS +: COST_BITS] = lr[d];
    end
  end
  // line FSM, Lp/minLp recurrence and the registered output stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      dir_q <= 1'b0;
      width_q <= '0;
      min_q <= '0;
      max_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      n <= '0;
      min_lp <= '0;
      o_valid <= 1'b0;
      o_cost <= '0;
      o_line_done <= 1'b0;
      for (int d = 0; d < DISPD; d++) lp[d] <= '0;
    end else begin
      o_line_done <= 1'b0;
      if (i_line_start) begin
        state <= RUN;
        dir_q <= i_dir;
        width_q <= i_width;
        min_q <= i_min_disp;
        max_q <= i_max_disp;
        p1_q <= i_P1;
        p2_q <= i_P2;
        n <= '0;
        min_lp <= '0;
        o_valid <= 1'b0;
        for (int d = 0; d < DISPD; d++) lp[d] <= '0;
      end else begin
        if (acc) begin
          n <= n + 1'b1;
          min_lp <= lr_min;
          o_cost <= lr_flat;
          o_valid <= 1'b1;
          for (int d = 0; d < DISPD; d++) lp[d] <= lr[d];
        end else if (i_out_ready) o_valid <= 1'b0;
        if (state == RUN && (width_q == '0 || (acc && n + 1'b1 == width_q))) state <= FLUSH;
        if (state == FLUSH && (!o_valid || i_out_ready)) begin
          state <= IDLE;
          o_line_done <= 1'b1;
        end
      end
    end
`ifdef SGBM_AGGR_WTA_EN
  // winner-take-all disparity registered alongside o_cost
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_best_disp <= '0;
    else if (acc) o_best_disp <= best + min_q[LW-1:0];
`endif
  // line buffer in image-column order; a same-address read returns the pre-write data
  always_ff @(posedge clk) begin
    if (acc) mem[wr_addr] <= lr_flat;
    o_rd_data <= mem[i_rd_addr];
  end
endmodule

// File: tb/tb_sgbm_aggr_path.sv
// tb_sgbm_aggr_path: randomized line-level checks of sgbm_aggr_path against a behavioural path-aggregation model
module tb_sgbm_aggr_path;
  localparam int D = 4, CB = 8, WB = 4, DB = 3;
  localparam int MAXC = (1 << CB) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic i_line_start = 1'b0, i_dir = 1'b0;
  logic [WB-1:0] i_width = '0, i_rd_addr = '0;
  logic [DB-1:0] i_min_disp = '0, i_max_disp = '0;
  logic [CB-1:0] i_P1 = '0, i_P2 = '0;
  logic [D*CB-1:0] i_cost = '0, o_cost, o_rd_data;
  logic i_valid = 1'b0, i_out_ready = 1'b1;
  logic o_ready, o_valid, o_line_done, o_busy;
`ifdef SGBM_AGGR_WTA_EN
  logic [1:0] o_best_disp;
  int best_q[$];
`endif
  int pass_cnt = 0, total = 0;
  int m_lp[D];
  int m_min, m_r, m_p1, m_p2;
  logic [D*CB-1:0] exp_q[$];
  logic [D*CB-1:0] buf_exp[16];
  logic [D*CB-1:0] fix_vec;

  always #5 clk = ~clk;

  sgbm_aggr_path #(.DISPD(D), .COST_BITS(CB), .WIDTH_BITS(WB)) dut (
    .clk(clk), .rst(rst), .i_line_start(i_line_start), .i_dir(i_dir), .i_width(i_width),
    .i_min_disp(i_min_disp), .i_max_disp(i_max_disp), .i_P1(i_P1), .i_P2(i_P2),
    .i_cost(i_cost), .i_valid(i_valid), .o_ready(o_ready), .o_cost(o_cost), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_line_done(o_line_done), .o_busy(o_busy)
`ifdef SGBM_AGGR_WTA_EN
    , .o_best_disp(o_best_disp)
`endif
  );

  task automatic model_px(input logic [D*CB-1:0] cv, input int mnd, output logic [D*CB-1:0] ov, output int best);
    int nl[D];
    int lo, c, left, right, x, v;
    lo = MAXC;
    best = 0;
    ov = '0;
    for (int d = 0; d < D; d++) begin
      c = int'(cv[d*CB +: CB]);
      if (d >= m_r) nl[d] = MAXC;
      else begin
        left = MAXC;
        right = MAXC;
        if (d > 0) left = m_lp[d-1];
        if (d + 1 < m_r && d + 1 < D) right = m_lp[d+1];
        x = m_lp[d];
        if (left + m_p1 < x) x = left + m_p1;
        if (right + m_p1 < x) x = right + m_p1;
        if (m_min + m_p2 < x) x = m_min + m_p2;
        v = c + x - m_min;
        nl[d] = (v > MAXC) ? MAXC : v;
        if (nl[d] < lo) begin
          lo = nl[d];
          best = d;
        end
      end
      ov[d*CB +: CB] = CB'(nl[d]);
    end
    m_lp = nl;
    m_min = lo;
    best = (best + mnd) % D;
  endtask

  task automatic run_line(input bit dir, input int w, input int mn, input int mx, input int p1, input int p2,
                          input bit fixed, input int stall_at, input bit rnd, input int abort_after, input string tag);
    int sent, recv, cyc, last_cons, done_cyc, stall_left, eb, addr, exp_done;
    bit stall_done, held_ok;
    logic [D*CB-1:0] cv, ev, held, first_raw, raw_exp, inact;
    exp_q.delete();
`ifdef SGBM_AGGR_WTA_EN
    best_q.delete();
`endif
    m_r = (mx - mn > 1) ? mx - mn : 1;
    m_p1 = p1;
    m_p2 = p2;
    m_min = 0;
    for (int d = 0; d < D; d++) m_lp[d] = 0;
    inact = '0;
    for (int d = 0; d < D; d++) if (d >= m_r) inact[d*CB +: CB] = '1;
    @(negedge clk);
    i_line_start = 1'b1; i_dir = dir; i_width = WB'(w); i_min_disp = DB'(mn); i_max_disp = DB'(mx);
    i_P1 = CB'(p1); i_P2 = CB'(p2); i_valid = 1'b0; i_out_ready = 1'b1;
    @(negedge clk);
    i_line_start = 1'b0;
    sent = 0; recv = 0; cyc = 0; last_cons = -10; done_cyc = -1; stall_left = 0;
    stall_done = 0; held_ok = 0; held = '0; first_raw = '0;
    total++; if (o_busy !== 1'b1) $display("FAIL %s busy_in_line got %b want 1", tag, o_busy); else pass_cnt++;
    while (cyc < 300) begin
      if (o_line_done) begin
        done_cyc = cyc;
        break;
      end
      if (stall_at >= 0 && !stall_done && sent == stall_at && o_valid) begin
        stall_left = 5;
        stall_done = 1;
      end
      i_out_ready = (stall_left > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (stall_left > 0) stall_left--;
      i_valid = (sent < w) && (!rnd || $urandom_range(0, 3) != 0);
      cv = fix_vec;
      if (!fixed) for (int d = 0; d < D; d++) cv[d*CB +: CB] = CB'($urandom_range(0, MAXC));
      i_cost = cv;
      #1;
      if (o_valid && !i_out_ready) begin
        total++; if (o_ready !== 1'b0) $display("FAIL %s ready_in_stall got %b want 0", tag, o_ready); else pass_cnt++;
        if (held_ok) begin
          total++; if (o_cost !== held) $display("FAIL %s cost_held got %h want %h", tag, o_cost, held); else pass_cnt++;
        end
        held = o_cost;
        held_ok = 1;
      end else held_ok = 0;
      if (o_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL %s unexpected_output got %h want none", tag, o_cost);
        end else begin
          ev = exp_q.pop_front();
          total++; if (o_cost !== ev) $display("FAIL %s cost_out%0d got %h want %h", tag, recv, o_cost, ev); else pass_cnt++;
`ifdef SGBM_AGGR_WTA_EN
          eb = best_q.pop_front();
          total++; if (o_best_disp !== 2'(eb)) $display("FAIL %s best_disp got %0d want %0d", tag, o_best_disp, eb); else pass_cnt++;
`endif
        end
        if (recv == 0) begin
          raw_exp = (first_raw & ~inact) | inact;
          total++; if (o_cost !== raw_exp) $display("FAIL %s first_is_raw got %h want %h", tag, o_cost, raw_exp); else pass_cnt++;
        end
        if (inact != '0) begin
          total++; if ((o_cost & inact) !== inact) $display("FAIL %s inactive_lanes got %h want %h", tag, o_cost & inact, inact); else pass_cnt++;
        end
        recv++;
        last_cons = cyc;
      end
      if (i_valid && o_ready) begin
        model_px(cv, mn, ev, eb);
        exp_q.push_back(ev);
`ifdef SGBM_AGGR_WTA_EN
        best_q.push_back(eb);
`endif
        addr = dir ? w - 1 - sent : sent;
        buf_exp[addr] = ev;
        if (sent == 0) first_raw = cv;
        sent++;
      end
      @(posedge clk);
      cyc++;
      if (abort_after >= 0 && sent >= abort_after) break;
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (abort_after >= 0) begin
      @(negedge clk);
      i_out_ready = 1'b0;
      total++; if (o_line_done !== 1'b0 || done_cyc >= 0) $display("FAIL %s aborted_line_done got %b/%0d want 0/-1", tag, o_line_done, done_cyc); else pass_cnt++;
    end else begin
      exp_done = (w == 0) ? 2 : last_cons + 1;
      total++; if (done_cyc != exp_done) $display("FAIL %s line_done_cycle got %0d want %0d", tag, done_cyc, exp_done); else pass_cnt++;
      total++; if (recv != w) $display("FAIL %s output_count got %0d want %0d", tag, recv, w); else pass_cnt++;
      total++; if (o_busy !== 1'b0) $display("FAIL %s busy_after_done got %b want 0", tag, o_busy); else pass_cnt++;
      for (int a = 0; a < w; a++) begin
        i_rd_addr = WB'(a);
        @(negedge clk);
        total++; if (o_rd_data !== buf_exp[a]) $display("FAIL %s linebuf[%0d] got %h want %h", tag, a, o_rd_data, buf_exp[a]); else pass_cnt++;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++; if (o_valid !== 1'b0) $display("FAIL %s o_valid got %b want 0", tag, o_valid); else pass_cnt++;
    total++; if (o_line_done !== 1'b0) $display("FAIL %s o_line_done got %b want 0", tag, o_line_done); else pass_cnt++;
    total++; if (o_busy !== 1'b0) $display("FAIL %s o_busy got %b want 0", tag, o_busy); else pass_cnt++;
    total++; if (o_ready !== 1'b0) $display("FAIL %s o_ready got %b want 0", tag, o_ready); else pass_cnt++;
    total++; if (o_cost !== '0) $display("FAIL %s o_cost got %h want 0", tag, o_cost); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
  endtask

  task automatic test_example();
    run_line(1'b0, 3, 0, 4, 1, 4, 1'b1, -1, 1'b0, -1, "example_dir0");
  endtask

  task automatic test_dir_rev();
    run_line(1'b1, 3, 0, 4, 1, 4, 1'b1, -1, 1'b0, -1, "example_dir1");
    i_rd_addr = WB'(2);
    @(negedge clk);
    total++; if (o_rd_data !== fix_vec) $display("FAIL dir1_addr2_raw got %h want %h", o_rd_data, fix_vec); else pass_cnt++;
  endtask

  task automatic test_inactive();
    run_line(1'b0, 6, 0, 2, 3, 20, 1'b0, -1, 1'b0, -1, "inactive");
  endtask

  task automatic test_stall();
    run_line(1'b0, 4, 0, 4, 1, 4, 1'b1, 1, 1'b0, -1, "stall_fixed");
    run_line(1'b0, 6, 1, 4, 5, 30, 1'b0, 2, 1'b0, -1, "stall_rand");
  endtask

  task automatic test_abort();
    run_line(1'b0, 3, 0, 4, 1, 4, 1'b0, -1, 1'b0, 1, "abort_old");
    run_line(1'b0, 3, 0, 4, 1, 4, 1'b0, -1, 1'b0, -1, "abort_new");
  endtask

  task automatic test_width0();
    run_line(1'b1, 0, 0, 4, 1, 4, 1'b0, -1, 1'b0, -1, "width0");
  endtask

  task automatic test_reset_mid();
    run_line(1'b0, 5, 0, 4, 2, 6, 1'b0, -1, 1'b0, 2, "rstmid_line");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_outputs("rstmid");
    @(negedge clk);
    rst = 1'b1;
    run_line(1'b0, 3, 0, 4, 1, 4, 1'b1, -1, 1'b0, -1, "after_rst");
  endtask

  task automatic test_random();
    int mn, mx, p1;
    for (int k = 0; k < 8; k++) begin
      mn = $urandom_range(0, 3);
      mx = $urandom_range(0, 7);
      p1 = $urandom_range(0, 20);
      run_line(1'($urandom_range(0, 1)), $urandom_range(0, 12), mn, mx, p1, p1 + $urandom_range(0, 60),
               1'b0, -1, 1'b1, -1, "random");
    end
  endtask

  initial begin
    fix_vec = {8'd9, 8'd7, 8'd2, 8'd5};
    test_reset();
    test_example();
    test_dir_rev();
    test_inactive();
    test_stall();
    test_abort();
    test_width0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
